// File: rtl/output_link_tx_if.sv
// Signal bundle for one output channel: crossbar side (flit in, ready/lock out)
// and link side (flit out, per-VC dequeue acks in, sticky error out).
interface output_link_tx_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NVC        = 4,
  parameter int VCW        = 2
);
  logic [DATA_WIDTH-1:0] idata;
  logic                  ivalid;
  logic [VCW-1:0]        ivch;
  logic [NVC-1:0]        ordy;
  logic [NVC-1:0]        olck;
  logic [DATA_WIDTH-1:0] odata;
  logic                  ovalid;
  logic [VCW-1:0]        ovch;
  logic [NVC-1:0]        iack;
  logic                  err;

  modport master (
    output idata, ivalid, ivch, iack,
    input  ordy, olck, odata, ovalid, ovch, err
  );

  modport slave (
    input  idata, ivalid, ivch, iack,
    output ordy, olck, odata, ovalid, ovch, err
  );
endinterface

// File: rtl/output_link_tx.sv
// Transmit side of one router channel: registers accepted flits onto the link,
// tracks per-VC downstream credits and packet locks, flags protocol errors.
module output_link_tx #(
  parameter int DEPTH      = 4,
  parameter int CW         = 3,
  parameter int DATA_WIDTH = 16,
  parameter int NVC        = 4,
  parameter int VCW        = 2
) (
  input  logic               clk,
  input  logic               reset,
  output_link_tx_if.slave    lnk
);

  // Flit type lives in the top three bits of the flit.
  localparam int TYPE_MSB = DATA_WIDTH - 1;
  localparam int TYPE_LSB = DATA_WIDTH - 3;

  localparam logic [2:0] TYPE_NONE     = 3'd0;
  localparam logic [2:0] TYPE_HEAD     = 3'd1;
  localparam logic [2:0] TYPE_BODY     = 3'd2;
  localparam logic [2:0] TYPE_TAIL     = 3'd3;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [NVC-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NVC-1:0]         lck_q, lck_d;
  logic [DATA_WIDTH-1:0]  odata_q, odata_d;
  logic                   ovalid_q, ovalid_d;
  logic [VCW-1:0]         ovch_q, ovch_d;
  logic                   err_q, err_d;

  logic [NVC-1:0] ordy_w;
  logic           acc;
  logic [2:0]     ftype;

  always_comb begin
    ordy_w = '0;
    for (int v = 0; v < NVC; v++) ordy_w[v] = (cnt_q[v] != '0);
  end

  always_comb begin
    ftype    = lnk.idata[TYPE_MSB:TYPE_LSB];
    acc      = lnk.ivalid && ordy_w[lnk.ivch];
    cnt_d    = cnt_q;
    lck_d    = lck_q;
    err_d    = err_q;
    odata_d  = acc ? lnk.idata : '0;
    ovalid_d = acc;
    ovch_d   = acc ? lnk.ivch : '0;

    if (lnk.ivalid && !acc) err_d = 1'b1;

    // A send and a credit return on the same VC in one cycle cancel out.
    for (int v = 0; v < NVC; v++) begin
      if (acc && (lnk.ivch == VCW'(v)) && !lnk.iack[v]) begin
        cnt_d[v] = cnt_q[v] - CW'(1);
      end else if (lnk.iack[v] && !(acc && (lnk.ivch == VCW'(v)))) begin
        if (cnt_q[v] == DEPTH_C) err_d = 1'b1;
        else                     cnt_d[v] = cnt_q[v] + CW'(1);
      end
    end

    if (acc) begin
      case (ftype)
        TYPE_HEAD: begin
          if (lck_q[lnk.ivch]) err_d = 1'b1;
          lck_d[lnk.ivch] = 1'b1;
        end
        TYPE_TAIL: begin
          if (!lck_q[lnk.ivch]) err_d = 1'b1;
          lck_d[lnk.ivch] = 1'b0;
        end
        TYPE_BODY: begin
          if (!lck_q[lnk.ivch]) err_d = 1'b1;
        end
        TYPE_NONE: ;
        // Remaining types are single-flit packets and must not interrupt one.
        default: begin
          if (lck_q[lnk.ivch]) err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= {NVC{DEPTH_C}};
      lck_q    <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      lck_q    <= lck_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      ovch_q   <= ovch_d;
      err_q    <= err_d;
    end
  end

  assign lnk.ordy   = ordy_w;
  assign lnk.olck   = lck_q;
  assign lnk.odata  = odata_q;
  assign lnk.ovalid = ovalid_q;
  assign lnk.ovch   = ovch_q;
  assign lnk.err    = err_q;

endmodule

// File: tb/tb_output_link_tx.sv
// Bench for output_link_tx: directed table, hand-written corner sequences and
// randomized traffic, all checked against a credit/lock reference model.
module tb_output_link_tx;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int NVC   = 4;
  localparam int VCW   = 2;

  localparam logic [2:0] T_NONE = 3'd0, T_HEAD = 3'd1, T_BODY = 3'd2, T_TAIL = 3'd3;
  localparam logic [2:0] T_HT   = 3'd4, T_TEST = 3'd5, T_ACK  = 3'd6, T_ACKB = 3'd7;

  logic clk = 1'b0;
  logic reset;

  output_link_tx_if #(.DATA_WIDTH(DW), .NVC(NVC), .VCW(VCW)) lnk();

  output_link_tx #(.DEPTH(DEPTH), .CW(3), .DATA_WIDTH(DW), .NVC(NVC), .VCW(VCW)) dut (
    .clk   (clk),
    .reset (reset),
    .lnk   (lnk)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int          m_cnt [NVC];
  bit          m_lck [NVC];
  bit          m_err;
  bit          m_ovalid;
  logic [DW-1:0]  m_odata;
  logic [VCW-1:0] m_ovch;

  typedef struct {
    bit             rst;
    logic [DW-1:0]  data;
    bit             valid;
    logic [VCW-1:0] vch;
    logic [NVC-1:0] ack;
    bit             e_ovalid;
    logic [NVC-1:0] e_ordy;
    logic [NVC-1:0] e_olck;
    bit             e_err;
    logic [11:0]    e_cnt;   // {cnt3,cnt2,cnt1,cnt0}
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] flit(input logic [2:0] t, input logic [12:0] pay);
    return {t, pay};
  endfunction

  function automatic vec_t mk(input bit rst, input logic [DW-1:0] d, input bit v,
                              input logic [VCW-1:0] ch, input logic [NVC-1:0] ack,
                              input bit eov, input logic [NVC-1:0] erdy,
                              input logic [NVC-1:0] elck, input bit eerr,
                              input logic [11:0] ecnt);
    vec_t r;
    r.rst = rst; r.data = d; r.valid = v; r.vch = ch; r.ack = ack;
    r.e_ovalid = eov; r.e_ordy = erdy; r.e_olck = elck; r.e_err = eerr; r.e_cnt = ecnt;
    return r;
  endfunction

  task automatic model_step(input bit rst, input logic [DW-1:0] d, input bit v,
                            input int ch, input logic [NVC-1:0] ack);
    bit acc;
    logic [2:0] t;
    if (rst) begin
      for (int i = 0; i < NVC; i++) begin m_cnt[i] = DEPTH; m_lck[i] = 0; end
      m_err = 0; m_ovalid = 0; m_odata = '0; m_ovch = '0;
      return;
    end
    acc = v && (m_cnt[ch] > 0);
    if (v && !acc) m_err = 1;
    for (int i = 0; i < NVC; i++) begin
      int net;
      net = int'(ack[i]) - ((acc && ch == i) ? 1 : 0);
      if (net > 0 && m_cnt[i] == DEPTH) m_err = 1;
      else m_cnt[i] = m_cnt[i] + net;
    end
    t = d[DW-1 -: 3];
    if (acc) begin
      if (t == T_HEAD) begin
        if (m_lck[ch]) m_err = 1;
        m_lck[ch] = 1;
      end else if (t == T_TAIL) begin
        if (!m_lck[ch]) m_err = 1;
        m_lck[ch] = 0;
      end else if (t == T_BODY) begin
        if (!m_lck[ch]) m_err = 1;
      end else if (t != T_NONE) begin
        if (m_lck[ch]) m_err = 1;
      end
    end
    m_ovalid = acc;
    m_odata  = acc ? d : '0;
    m_ovch   = acc ? VCW'(ch) : '0;
  endtask

  task automatic check_model();
    logic [NVC-1:0] erdy, elck;
    for (int i = 0; i < NVC; i++) begin
      erdy[i] = (m_cnt[i] != 0);
      elck[i] = m_lck[i];
    end
    chk("ovalid", 32'(lnk.ovalid), 32'(m_ovalid));
    chk("odata",  32'(lnk.odata),  32'(m_odata));
    if (m_ovalid) chk("ovch", 32'(lnk.ovch), 32'(m_ovch));
    chk("ordy",   32'(lnk.ordy),   32'(erdy));
    chk("olck",   32'(lnk.olck),   32'(elck));
    chk("err",    32'(lnk.err),    32'(m_err));
    for (int i = 0; i < NVC; i++) chk("cnt", 32'(dut.cnt_q[i]), 32'(m_cnt[i]));
  endtask

  task automatic cycle(input bit rst, input logic [DW-1:0] d, input bit v,
                       input int ch, input logic [NVC-1:0] ack);
    reset      = rst;
    lnk.idata  = d;
    lnk.ivalid = v;
    lnk.ivch   = VCW'(ch);
    lnk.iack   = ack;
    model_step(rst, d, v, ch, ack);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle(); cycle(0, '0, 0, 0, '0); endtask

  initial begin
    reset = 1; lnk.idata = '0; lnk.ivalid = 0; lnk.ivch = '0; lnk.iack = '0;
    for (int i = 0; i < NVC; i++) begin m_cnt[i] = DEPTH; m_lck[i] = 0; end
    m_err = 0; m_ovalid = 0; m_odata = '0; m_ovch = '0;

    // rst, data, valid, vch, ack, ovalid, ordy, olck, err, cnt{3,2,1,0}
    tbl.push_back(mk(1, '0, 0, 0, 4'b0000, 0, 4'b1111, 4'b0000, 0, {3'd4,3'd4,3'd4,3'd4}));
    tbl.push_back(mk(0, '0, 0, 0, 4'b0000, 0, 4'b1111, 4'b0000, 0, {3'd4,3'd4,3'd4,3'd4}));
    tbl.push_back(mk(0, flit(T_HEAD, 13'h0a1), 1, 2, 4'b0000, 1, 4'b1111, 4'b0100, 0, {3'd4,3'd3,3'd4,3'd4}));
    tbl.push_back(mk(0, flit(T_BODY, 13'h0b2), 1, 2, 4'b0000, 1, 4'b1111, 4'b0100, 0, {3'd4,3'd2,3'd4,3'd4}));
    tbl.push_back(mk(0, flit(T_TAIL, 13'h0c3), 1, 2, 4'b0000, 1, 4'b1111, 4'b0000, 0, {3'd4,3'd1,3'd4,3'd4}));
    tbl.push_back(mk(0, '0, 0, 0, 4'b0000, 0, 4'b1111, 4'b0000, 0, {3'd4,3'd1,3'd4,3'd4}));
    tbl.push_back(mk(1, '0, 0, 0, 4'b0000, 0, 4'b1111, 4'b0000, 0, {3'd4,3'd4,3'd4,3'd4}));
    tbl.push_back(mk(0, flit(T_HT, 13'h011), 1, 1, 4'b0000, 1, 4'b1111, 4'b0000, 0, {3'd4,3'd4,3'd3,3'd4}));
    tbl.push_back(mk(0, flit(T_HT, 13'h022), 1, 1, 4'b0000, 1, 4'b1111, 4'b0000, 0, {3'd4,3'd4,3'd2,3'd4}));
    tbl.push_back(mk(0, flit(T_HT, 13'h033), 1, 1, 4'b0000, 1, 4'b1111, 4'b0000, 0, {3'd4,3'd4,3'd1,3'd4}));
    tbl.push_back(mk(0, flit(T_HT, 13'h044), 1, 1, 4'b0000, 1, 4'b1101, 4'b0000, 0, {3'd4,3'd4,3'd0,3'd4}));
    tbl.push_back(mk(0, flit(T_HT, 13'h055), 1, 1, 4'b0000, 0, 4'b1101, 4'b0000, 1, {3'd4,3'd4,3'd0,3'd4}));
    tbl.push_back(mk(0, '0, 0, 0, 4'b0010, 0, 4'b1111, 4'b0000, 1, {3'd4,3'd4,3'd1,3'd4}));
    tbl.push_back(mk(0, flit(T_HT, 13'h066), 1, 1, 4'b0010, 1, 4'b1111, 4'b0000, 1, {3'd4,3'd4,3'd1,3'd4}));
    tbl.push_back(mk(1, '0, 0, 0, 4'b0000, 0, 4'b1111, 4'b0000, 0, {3'd4,3'd4,3'd4,3'd4}));
    tbl.push_back(mk(0, '0, 0, 0, 4'b1000, 0, 4'b1111, 4'b0000, 1, {3'd4,3'd4,3'd4,3'd4}));
    tbl.push_back(mk(1, '0, 0, 0, 4'b0000, 0, 4'b1111, 4'b0000, 0, {3'd4,3'd4,3'd4,3'd4}));
    tbl.push_back(mk(0, flit(T_HEAD, 13'h0d4), 1, 0, 4'b0000, 1, 4'b1111, 4'b0001, 0, {3'd4,3'd4,3'd4,3'd3}));
    tbl.push_back(mk(1, flit(T_BODY, 13'h0e5), 1, 0, 4'b0000, 0, 4'b1111, 4'b0000, 0, {3'd4,3'd4,3'd4,3'd4}));
    tbl.push_back(mk(0, flit(T_BODY, 13'h0f6), 1, 0, 4'b0000, 1, 4'b1111, 4'b0000, 1, {3'd4,3'd4,3'd4,3'd3}));

    for (int k = 0; k < tbl.size(); k++) begin
      vec_t r;
      r = tbl[k];
      cycle(r.rst, r.data, r.valid, int'(r.vch), r.ack);
      chk("tbl_ovalid", 32'(lnk.ovalid), 32'(r.e_ovalid));
      chk("tbl_odata",  32'(lnk.odata),  r.e_ovalid ? 32'(r.data) : 32'd0);
      if (r.e_ovalid) chk("tbl_ovch", 32'(lnk.ovch), 32'(r.vch));
      chk("tbl_ordy",   32'(lnk.ordy),   32'(r.e_ordy));
      chk("tbl_olck",   32'(lnk.olck),   32'(r.e_olck));
      chk("tbl_err",    32'(lnk.err),    32'(r.e_err));
      for (int i = 0; i < NVC; i++) chk("tbl_cnt", 32'(dut.cnt_q[i]), 32'(r.e_cnt[i*3 +: 3]));
    end

    // Send and ack on a full VC cancel: no saturation error.
    cycle(1, '0, 0, 0, '0);
    cycle(0, flit(T_HEAD, 13'h101), 1, 3, 4'b1000);
    chk("hs_cnt3_full", 32'(dut.cnt_q[3]), 32'd4);
    chk("hs_err_cancel", 32'(lnk.err), 32'd0);
    // TAIL followed immediately by a new HEAD on the same VC.
    cycle(0, flit(T_TAIL, 13'h102), 1, 3, 4'b0000);
    chk("hs_olck_tail", 32'(lnk.olck[3]), 32'd0);
    cycle(0, flit(T_HEAD, 13'h103), 1, 3, 4'b0000);
    chk("hs_olck_rehead", 32'(lnk.olck[3]), 32'd1);
    chk("hs_ovch", 32'(lnk.ovch), 32'd3);
    // HEADTAIL inside an open packet is a protocol error.
    cycle(0, flit(T_HT, 13'h104), 1, 3, 4'b0000);
    chk("hs_ht_in_pkt", 32'(lnk.err), 32'd1);
    idle();
    chk("hs_idle_ovalid", 32'(lnk.ovalid), 32'd0);

    // Randomized traffic in short segments so sticky err does not mask everything.
    for (int seg = 0; seg < 20; seg++) begin
      cycle(1, '0, 0, 0, '0);
      for (int c = 0; c < 60; c++) begin
        bit v;
        int ch;
        logic [2:0] t;
        logic [NVC-1:0] ack;
        ch = int'($urandom_range(0, NVC-1));
        v  = ($urandom_range(0, 3) != 0);
        if (m_cnt[ch] == 0 && $urandom_range(0, 9) != 0) v = 0;
        if ($urandom_range(0, 19) == 0) t = 3'($urandom_range(0, 7));
        else if (m_lck[ch]) t = ($urandom_range(0, 2) == 0) ? T_TAIL : T_BODY;
        else begin
          case ($urandom_range(0, 5))
            0: t = T_HEAD;
            1: t = T_HT;
            2: t = T_TEST;
            3: t = T_ACK;
            4: t = T_ACKB;
            default: t = T_NONE;
          endcase
        end
        for (int i = 0; i < NVC; i++)
          ack[i] = ((m_cnt[i] < DEPTH) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 99) == 0);
        cycle(0, flit(t, 13'($urandom)), v, ch, ack);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
